ub_burst_ctrl: RTL and testbench

- Command-driven burst sequencer for the 256-entry x 128-bit unified buffer BRAM (write port A, read port B, both sampled on negedge clk).
- Accepts one burst command at a time, either a write burst from the host/DMA side or a read burst toward the systolic array feeder.
- Generates BRAM enables and addresses with 8-bit wrap-around.
- Hides the half-cycle read latency behind a 2-entry output FIFO with valid/ready backpressure.

---
 rtl/ub_burst_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ub_burst_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_burst_ctrl.sv
// ub_burst_ctrl: single-command write/read burst sequencer for the 256 x 128-bit unified buffer BRAM.
// Latency: a write beat reaches the BRAM in its accept cycle; a read beat issued at posedge k is on rd_data from posedge k+1.
// Backpressure: wr_valid low stalls writes; rd_ready low holds the 2-entry read FIFO, which throttles BRAM read issue.
// Optional build macro UB_BURST_CTRL_PERF_CNT_EN adds saturating perf_busy_cycles / perf_stall_cycles outputs.
module ub_burst_ctrl #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              done,
  output logic              busy,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
`ifdef UB_BURST_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  // One extra bit so a 256-beat read can count past the last address.
  logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [ADDR_W-1:0]   addrb_q, addrb_d;
  // Registered read enable; it doubles as the in-flight flag because the
  // BRAM answers at the negedge inside the cycle the enable is presented.
  logic                inflight_q, inflight_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   fifo_mem_q [2];
  logic [DATA_W-1:0]   fifo_mem_d [2];
  logic                fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic                fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;

  logic                wr_fire;
  logic                push;
  logic                pop;
  logic [2:0]          fifo_occ;
  logic                fifo_room;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign wr_ready   = (state_q == ST_WRITE);
  assign wr_fire    = wr_ready & wr_valid;
  assign bram_wea   = wr_fire;
  assign bram_addra = base_q + issue_cnt_q[ADDR_W-1:0];
  assign bram_dina  = wr_data;
  assign bram_enb   = inflight_q;
  assign bram_addrb = addrb_q;
  assign rd_valid   = (fifo_cnt_q != 2'd0);
  assign rd_data    = fifo_mem_q[fifo_rd_ptr_q];
  assign rd_last    = rd_valid && (ret_cnt_q == len_q);
  assign done       = done_q;
  assign push       = inflight_q;
  assign pop        = rd_valid & rd_ready;

  // Occupancy after this edge counts the beat being read now and credits a
  // pop in the same cycle, so a steady consumer sees one beat per cycle.
  assign fifo_occ  = {1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign fifo_room = (fifo_occ < 3'(FIFO_DEPTH));

  // Next-state, burst counters, read issue and FIFO bookkeeping.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    issue_cnt_d   = issue_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    addrb_d       = addrb_q;
    inflight_d    = 1'b0;
    done_d        = 1'b0;
    fifo_mem_d    = fifo_mem_q;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          base_d      = cmd_addr;
          len_d       = cmd_len;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = cmd_op ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_fire) begin
          issue_cnt_d = issue_cnt_q + (ADDR_W+1)'(1);
          if (issue_cnt_q[ADDR_W-1:0] == len_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if ((issue_cnt_q <= {1'b0, len_q}) && fifo_room) begin
          inflight_d  = 1'b1;
          addrb_d     = base_q + issue_cnt_q[ADDR_W-1:0];
          issue_cnt_d = issue_cnt_q + (ADDR_W+1)'(1);
        end
        if (pop) begin
          ret_cnt_d = ret_cnt_q + ADDR_W'(1);
          if (ret_cnt_q == len_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      fifo_mem_d[fifo_wr_ptr_q] = bram_doutb;
      fifo_wr_ptr_d             = ~fifo_wr_ptr_q;
    end
    if (pop) begin
      fifo_rd_ptr_d = ~fifo_rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Control state with synchronous active-low reset; reset aborts any burst.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      ret_cnt_q     <= '0;
      addrb_q       <= '0;
      inflight_q    <= 1'b0;
      done_q        <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
      addrb_q       <= addrb_d;
      inflight_q    <= inflight_d;
      done_q        <= done_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // FIFO storage needs no reset: an empty count hides stale entries.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

`ifdef UB_BURST_CTRL_PERF_CNT_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall_now;

  assign stall_now = ((state_q == ST_READ) && rd_valid && !rd_ready) ||
                     ((state_q == ST_WRITE) && !wr_valid);

  // Saturating busy and stall cycle counters.
  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (busy && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 32'd1;
    if (stall_now && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_ub_burst_ctrl.sv
// Bench for ub_burst_ctrl: behavioural BRAM plus a reference memory of every written beat.
// Directed bursts (pattern, wrap, full length, reset abort, held command) then random bursts.
// Reads compare beat order, rd_last, issue address, FIFO capacity and done/idle handshakes.
module tb_ub_burst_ctrl;
  localparam int DW = 128;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          done;
  logic          busy;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;
  logic          bram_enb;
  logic [AW-1:0] bram_addrb;
  logic [DW-1:0] bram_doutb;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] bram    [256];

  ub_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .busy(busy),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  always #5 clk = ~clk;

  // Block RAM: both ports sample on the falling edge.
  always @(negedge clk) begin
    if (bram_wea) bram[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= bram[bram_addrb];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write burst; returns inside the cycle where done should be high.
  task automatic do_write(input logic [7:0] a, input logic [7:0] l, input bit stall, input bit pat);
    int i;
    int cyc;
    logic [7:0]  ea;
    logic [DW-1:0] d;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = a; cmd_len = l; wr_valid = 1'b0;
    #1;
    chk("wr_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    i = 0; cyc = 0;
    while (i <= int'(l) && cyc < 1500) begin
      wr_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pat) begin
        d = '0;
        d[7:0] = 8'hA0 + i[7:0];
      end else begin
        d = {$urandom, $urandom, $urandom, $urandom};
      end
      wr_data = d;
      #1;
      chk("wr_ready", wr_ready, 1'b1);
      chk("wr_busy", busy, 1'b1);
      chk("wr_done_early", done, 1'b0);
      chk("wr_wea", bram_wea, wr_valid);
      if (wr_valid) begin
        ea = a + i[7:0];
        chk("wr_addra", bram_addra, ea);
        chk("wr_dina", bram_dina, d);
        ref_mem[ea] = d;
        i++;
      end
      tick();
      cyc++;
    end
    wr_valid = 1'b0;
    #1;
    chk("wr_timeout", cyc < 1500, 1'b1);
    chk("wr_done", done, 1'b1);
    chk("wr_idle_busy", busy, 1'b0);
    chk("wr_idle_cmd_ready", cmd_ready, 1'b1);
    chk("wr_idle_wr_ready", wr_ready, 1'b0);
  endtask

  // Read burst. mode 0: rd_ready=1, 1: random, 2: pattern 1,0,0,1.
  // hold keeps the same command offered while busy.
  task automatic do_read(input logic [7:0] a, input logic [7:0] l, input int mode, input bit hold);
    int popped;
    int issued;
    int cyc;
    int first_iss;
    int first_val;
    logic [7:0] ea;
    bit rdy;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = a; cmd_len = l; rd_ready = 1'b0;
    #1;
    chk("rd_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = hold;
    popped = 0; issued = 0; cyc = 0; first_iss = -1; first_val = -1;
    while (popped <= int'(l) && cyc < 1500) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 1) != 0);
        default: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      rd_ready = rdy;
      #1;
      chk("rd_busy", busy, 1'b1);
      chk("rd_done_early", done, 1'b0);
      if (hold) chk("rd_cmd_ready_while_busy", cmd_ready, 1'b0);
      if (bram_enb) begin
        ea = a + issued[7:0];
        chk("rd_addrb", bram_addrb, ea);
        chk("rd_no_overissue", issued <= int'(l), 1'b1);
        chk("rd_fifo_room", (issued - popped) <= 1, 1'b1);
        if (first_iss < 0) first_iss = cyc;
        issued++;
      end
      if (mode == 0) chk("rd_valid_timing", rd_valid, cyc >= 2);
      if (rd_valid) begin
        ea = a + popped[7:0];
        if (first_val < 0) first_val = cyc;
        chk("rd_data", rd_data, ref_mem[ea]);
        chk("rd_last", rd_last, popped == int'(l));
        if (rdy) popped++;
      end else begin
        chk("rd_last_when_empty", rd_last, 1'b0);
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    #1;
    chk("rd_timeout", cyc < 1500, 1'b1);
    chk("rd_done", done, 1'b1);
    chk("rd_idle_busy", busy, 1'b0);
    chk("rd_idle_cmd_ready", cmd_ready, 1'b1);
    chk("rd_idle_valid", rd_valid, 1'b0);
    chk("rd_issue_total", issued == int'(l) + 1, 1'b1);
    chk("rd_first_latency", first_val == first_iss + 1, 1'b1);
  endtask

  initial begin
    int popped;
    int cyc;
    logic [7:0] ra;
    logic [7:0] rl;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wea", bram_wea, 1'b0);
    chk("rst_enb", bram_enb, 1'b0);
    chk("rst_addra", bram_addra, 8'h00);
    chk("rst_addrb", bram_addrb, 8'h00);
    reset_n = 1'b1;
    tick();

    do_write(8'h10, 8'd3, 1'b0, 1'b1);
    do_read (8'h10, 8'd3, 0, 1'b0);

    do_write(8'h20, 8'd7, 1'b1, 1'b0);
    do_read (8'h20, 8'd7, 2, 1'b0);

    do_write(8'hFE, 8'd3, 1'b0, 1'b0);
    do_read (8'hFE, 8'd3, 0, 1'b0);

    // Abort a read burst with a one-cycle reset after two beats.
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 8'h30; cmd_len = 8'd7;
    #1;
    tick();
    cmd_valid = 1'b0;
    rd_ready = 1'b1;
    popped = 0; cyc = 0;
    while (popped < 2 && cyc < 50) begin
      #1;
      if (rd_valid) popped++;
      tick();
      cyc++;
    end
    chk("abort_timeout", cyc < 50, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("abort_rd_valid", rd_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_cmd_ready", cmd_ready, 1'b1);
    chk("abort_enb", bram_enb, 1'b0);
    rd_ready = 1'b0;
    tick();
    chk("abort_done_after", done, 1'b0);
    chk("abort_rd_valid_after", rd_valid, 1'b0);
    do_read(8'h10, 8'd3, 0, 1'b0);

    do_write(8'h55, 8'd0, 1'b0, 1'b0);
    do_read (8'h55, 8'd0, 0, 1'b1);
    do_read (8'h55, 8'd0, 0, 1'b0);

    do_write(8'd250, 8'd9, 1'b1, 1'b0);
    do_read (8'd250, 8'd9, 1, 1'b0);

    do_write(8'h80, 8'd255, 1'b0, 1'b0);
    do_read (8'h80, 8'd255, 1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom);
      rl = 8'($urandom_range(0, 24));
      do_write(ra, rl, 1'b1, 1'b0);
      do_read (ra, rl, 1, 1'b0);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
